// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory slave port between instruction
// fetch (master 0) and load/store (master 1). One transaction in flight at a
// time; round-robin arbitration; request fields are registered at acceptance
// and never forwarded combinationally to the slave.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0: instruction fetch
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic                m0_wen,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_resp_valid,
  output logic [DATA_W-1:0]   m0_rdata,
  // master 1: load/store
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic                m1_wen,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_resp_valid,
  output logic [DATA_W-1:0]   m1_rdata,
  // slave port
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic [ADDR_W-1:0]   s_addr,
  output logic                s_wen,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wmask,
  input  logic                s_resp_valid,
  input  logic [DATA_W-1:0]   s_rdata,
  // status
  output logic                busy,
  output logic                stray_resp
);

  localparam int MASK_W = DATA_W / 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              last_grant;   // master served by the last completed transaction
  logic              grant;        // master owning the in-flight transaction
  logic              arb_any;
  logic              arb_grant;    // winner of this cycle's arbitration (0/1)
  logic              accept;
  logic              in_wait;

  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  // Arbitration: a lone requester wins; on a tie the master that did not go last wins.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    arb_any   = m0_req_valid | m1_req_valid;
    arb_grant = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      arb_grant = ~last_grant;
    end else if (m1_req_valid) begin
      arb_grant = 1'b1;
    end
  end

  assign accept       = (state == IDLE) && arb_any;
  assign m0_req_ready = accept & ~arb_grant;
  assign m1_req_ready = accept &  arb_grant;

  // Next-state logic for the IDLE -> ISSUE -> WAIT transaction sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any)      state_nxt = ISSUE;
      ISSUE:   if (s_req_ready)  state_nxt = WAIT;
      WAIT:    if (s_resp_valid) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // State register; reset drops the FSM to IDLE at once, abandoning any transaction.
  // NOTE: clocked blocks use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the winning master's request fields and identity on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      grant   <= arb_grant;
      addr_q  <= arb_grant ? m1_addr  : m0_addr;
      wen_q   <= arb_grant ? m1_wen   : m0_wen;
      wdata_q <= arb_grant ? m1_wdata : m0_wdata;
      wmask_q <= arb_grant ? m1_wmask : m0_wmask;
    end
  end

  // Round-robin history: updated only when a transaction completes.
  // Reset value 1 lets master 0 win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           last_grant <= 1'b1;
    else if (in_wait && s_resp_valid)  last_grant <= grant;
  end

  // Sticky flag: a slave response outside WAIT belongs to no transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                stray_resp <= 1'b0;
    else if (s_resp_valid && state != WAIT) stray_resp <= 1'b1;
  end

  assign in_wait = (state == WAIT);

  // Slave request side: driven only from the registered copy.
  assign s_req_valid = (state == ISSUE);
  assign s_addr      = addr_q;
  assign s_wen       = wen_q;
  assign s_wdata     = wdata_q;
  assign s_wmask     = wmask_q;

  // Response routing: only the owner of the in-flight transaction sees the slave.
  assign m0_resp_valid = in_wait & ~grant & s_resp_valid;
  assign m1_resp_valid = in_wait &  grant & s_resp_valid;
  assign m0_rdata      = (in_wait && !grant) ? s_rdata : '0;
  assign m1_rdata      = (in_wait &&  grant) ? s_rdata : '0;

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed stimulus, a
// transaction-level reference model compared every cycle, and literal
// expectations at the key points of each scenario.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [MW-1:0] m0_wmask;
  logic          m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [MW-1:0] m1_wmask;
  logic          s_req_valid, s_req_ready, s_wen, s_resp_valid;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [MW-1:0] s_wmask;
  logic          busy, stray_resp;

  int vectors    = 0;
  int miscompares = 0;
  int hs_count   = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_rdata(s_rdata),
    .busy(busy), .stray_resp(stray_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // A transaction exists from acceptance until its response; "sent" marks
  // that the slave has taken the request.
  bit          mdl_txn   = 1'b0;
  bit          mdl_sent  = 1'b0;
  bit          mdl_owner = 1'b0;
  bit          mdl_last  = 1'b1;
  bit          mdl_stray = 1'b0;
  logic [AW-1:0] mdl_addr  = '0;
  logic          mdl_wen   = 1'b0;
  logic [DW-1:0] mdl_wdata = '0;
  logic [MW-1:0] mdl_wmask = '0;

  // Which master the arbiter should pick given current requests.
  function automatic bit pick();
    if (m0_req_valid && m1_req_valid) return (mdl_last == 1'b1) ? 1'b0 : 1'b1;
    return m1_req_valid ? 1'b1 : 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_txn = 0; mdl_sent = 0; mdl_owner = 0; mdl_last = 1; mdl_stray = 0;
      mdl_addr = '0; mdl_wen = 0; mdl_wdata = '0; mdl_wmask = '0;
    end else begin
      if (s_resp_valid && !(mdl_txn && mdl_sent)) mdl_stray = 1;
      if (!mdl_txn) begin
        if (m0_req_valid || m1_req_valid) begin
          mdl_owner = pick();
          if (mdl_owner) begin
            mdl_addr = m1_addr; mdl_wen = m1_wen; mdl_wdata = m1_wdata; mdl_wmask = m1_wmask;
          end else begin
            mdl_addr = m0_addr; mdl_wen = m0_wen; mdl_wdata = m0_wdata; mdl_wmask = m0_wmask;
          end
          mdl_txn  = 1;
          mdl_sent = 0;
        end
      end else if (!mdl_sent) begin
        if (s_req_ready) mdl_sent = 1;
      end else if (s_resp_valid) begin
        mdl_txn  = 0;
        mdl_sent = 0;
        mdl_last = mdl_owner;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      bit idle_pick, want0, want1, waiting;
      idle_pick = pick();
      want0   = !mdl_txn && (m0_req_valid || m1_req_valid) && (idle_pick == 1'b0);
      want1   = !mdl_txn && (m0_req_valid || m1_req_valid) && (idle_pick == 1'b1);
      waiting = mdl_txn && mdl_sent;
      check("m0_req_ready",  m0_req_ready, want0);
      check("m1_req_ready",  m1_req_ready, want1);
      check("busy",          busy, mdl_txn);
      check("s_req_valid",   s_req_valid, mdl_txn && !mdl_sent);
      check("s_addr",        s_addr, mdl_addr);
      check("s_wen",         s_wen, mdl_wen);
      check("s_wdata",       s_wdata, mdl_wdata);
      check("s_wmask",       s_wmask, mdl_wmask);
      check("m0_resp_valid", m0_resp_valid, waiting && !mdl_owner && s_resp_valid);
      check("m1_resp_valid", m1_resp_valid, waiting &&  mdl_owner && s_resp_valid);
      check("m0_rdata",      m0_rdata, (waiting && !mdl_owner) ? s_rdata : '0);
      check("m1_rdata",      m1_rdata, (waiting &&  mdl_owner) ? s_rdata : '0);
      check("stray_resp",    stray_resp, mdl_stray);
      if (s_req_valid && s_req_ready) hs_count++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 0; m0_addr = '0; m0_wen = 0; m0_wdata = '0; m0_wmask = '0;
    m1_req_valid = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
    s_req_ready = 0; s_resp_valid = 0; s_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[4];
    int hs_before;
    exp_order = '{0, 1, 0, 1};

    // Reset state
    idle_inputs();
    tick();
    tick();
    check("rst busy",        busy, 0);
    check("rst s_req_valid", s_req_valid, 0);
    check("rst stray_resp",  stray_resp, 0);
    check("rst s_addr",      s_addr, 0);
    rst = 0;

    // Single read from master 0
    m0_req_valid = 1; m0_addr = 32'h8000_0000; m0_wen = 0; s_req_ready = 1;
    #1;
    check("t1 c0 m0_req_ready", m0_req_ready, 1);
    check("t1 c0 m1_req_ready", m1_req_ready, 0);
    tick();
    m0_req_valid = 0;
    #1;
    check("t1 c1 s_req_valid", s_req_valid, 1);
    check("t1 c1 s_addr",      s_addr, 32'h8000_0000);
    tick();
    s_resp_valid = 1; s_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1 c2 m0_resp_valid", m0_resp_valid, 1);
    check("t1 c2 m0_rdata",      m0_rdata, 32'hDEAD_BEEF);
    check("t1 c2 m1_rdata",      m1_rdata, 0);
    tick();
    s_resp_valid = 0; s_rdata = '0; s_req_ready = 0;
    #1;
    check("t1 c3 busy", busy, 0);

    // Both masters continuously valid: grants alternate 0,1,0,1 after reset
    apply_reset();
    m0_req_valid = 1; m0_addr = 32'h100;
    m1_req_valid = 1; m1_addr = 32'h200;
    s_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2 grant", {m0_req_ready, m1_req_ready}, (exp_order[k] == 1) ? 2'b01 : 2'b10);
      tick();
      tick();
      s_resp_valid = 1; s_rdata = 32'hA000_0000 + k;
      #1;
      if (exp_order[k] == 0) begin
        check("t2 m0 resp",       m0_resp_valid, 1);
        check("t2 m1 no rdata",   m1_rdata, 0);
      end else begin
        check("t2 m1 resp",       m1_resp_valid, 1);
        check("t2 m0 no rdata",   m0_rdata, 0);
      end
      tick();
      s_resp_valid = 0; s_rdata = '0;
    end
    m0_req_valid = 0; m1_req_valid = 0; s_req_ready = 0;

    // Master 1 write with a slave stalling 3 cycles; inputs change after acceptance
    m1_req_valid = 1; m1_addr = 32'h44; m1_wen = 1; m1_wdata = 32'h1234_5678; m1_wmask = 4'hF;
    #1;
    check("t3 accept", m1_req_ready, 1);
    hs_before = hs_count;
    tick();
    m1_req_valid = 0; m1_addr = 32'hFFFF; m1_wen = 0; m1_wdata = '0; m1_wmask = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t3 stall s_req_valid", s_req_valid, 1);
      check("t3 stall s_addr",      s_addr, 32'h44);
      check("t3 stall s_wdata",     s_wdata, 32'h1234_5678);
      check("t3 stall s_wmask",     s_wmask, 4'hF);
      tick();
    end
    s_req_ready = 1;
    tick();
    s_req_ready = 0; s_resp_valid = 1; s_rdata = '0;
    #1;
    check("t3 m1_resp_valid", m1_resp_valid, 1);
    check("t3 m0_resp_valid", m0_resp_valid, 0);
    tick();
    s_resp_valid = 0;
    #1;
    check("t3 handshakes", hs_count - hs_before, 1);
    check("t3 busy",       busy, 0);

    // Master 0 read; its inputs change (new pending request) after acceptance
    m0_req_valid = 1; m0_addr = 32'hA0; m0_wen = 0; m0_wdata = '0; m0_wmask = '0;
    #1;
    check("t4 accept", m0_req_ready, 1);
    tick();
    m0_addr = 32'hBB; m0_wen = 1; m0_wdata = 32'h5555; m0_wmask = 4'h3;
    #1;
    check("t4 s_addr held",  s_addr, 32'hA0);
    check("t4 s_wen held",   s_wen, 0);
    check("t4 ready busy",   m0_req_ready, 0);
    s_req_ready = 1;
    tick();
    s_req_ready = 0; s_resp_valid = 1; s_rdata = 32'hCAFE_F00D;
    #1;
    check("t4 m0_rdata", m0_rdata, 32'hCAFE_F00D);
    tick();
    m0_req_valid = 0; s_resp_valid = 0; s_rdata = '0;

    // Stray response in IDLE
    tick();
    s_resp_valid = 1; s_rdata = 32'h11;
    #1;
    check("t5 m0 no resp", m0_resp_valid, 0);
    check("t5 m1 no resp", m1_resp_valid, 0);
    tick();
    s_resp_valid = 0; s_rdata = '0;
    #1;
    check("t5 stray set", stray_resp, 1);
    tick(); tick(); tick();
    check("t5 stray sticky", stray_resp, 1);
    rst = 1;
    #1;
    check("t5 stray cleared", stray_resp, 0);
    tick();
    rst = 0;

    // Reset asserted in WAIT
    m0_req_valid = 1; m0_addr = 32'h300; m0_wen = 0; s_req_ready = 1;
    tick();
    m0_req_valid = 0;
    tick();
    s_req_ready = 0;
    #1;
    check("t6 in WAIT busy", busy, 1);
    rst = 1;
    #1;
    check("t6 rst s_req_valid", s_req_valid, 0);
    check("t6 rst busy",        busy, 0);
    check("t6 rst m0_resp",     m0_resp_valid, 0);
    check("t6 rst m1_resp",     m1_resp_valid, 0);
    tick();
    rst = 0;
    s_resp_valid = 1; s_rdata = 32'h77;
    #1;
    check("t6 late resp dropped", m0_resp_valid, 0);
    tick();
    s_resp_valid = 0; s_rdata = '0;
    #1;
    check("t6 late resp stray", stray_resp, 1);
    m0_req_valid = 1; m0_addr = 32'h400;
    m1_req_valid = 1; m1_addr = 32'h500;
    #1;
    check("t6 tie m0_req_ready", m0_req_ready, 1);
    check("t6 tie m1_req_ready", m1_req_ready, 0);
    s_req_ready = 1;
    tick();
    m0_req_valid = 0; m1_req_valid = 0;
    tick();
    s_req_ready = 0; s_resp_valid = 1; s_rdata = 32'h4040_4040;
    #1;
    check("t6 post-reset m0 resp", m0_resp_valid, 1);
    tick();
    s_resp_valid = 0; s_rdata = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
